// File: rtl/keypad_scanner.sv
// keypad_scanner
// Scans a 4x4 active-low matrix keypad one row at a time, debounces presses
// and releases, and hands each accepted key to a consumer through a
// valid/acknowledge pair.
//
// Ports:
//   clk        system clock, rising edge only
//   rst_n      asynchronous active-low reset
//   col_n[3:0] column sense, active-low, asynchronous to clk
//   key_ack    consumer acknowledge, only meaningful while key_valid=1
//   row_n[3:0] row strobe, exactly one bit low
//   key_code   last reported key, row*4 + col
//   key_valid  key_code holds a key the consumer has not acknowledged
//   key_down   a debounced press is being held (PRESSED or RELEASE)
//   overflow   sticky: a key was dropped because key_valid was still set
//
// Optional feature: define KEYPAD_REPEAT_EN to enable auto-repeat while a
// key is held (first repeat after REPEAT_DELAY samples, then every
// REPEAT_RATE samples). Without it each press is reported exactly once.

module keypad_scanner #(
    parameter int SCAN_DIV         = 50000,
    parameter int DEBOUNCE_SAMPLES = 8,
    parameter int REPEAT_DELAY     = 500,
    parameter int REPEAT_RATE      = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] col_n,
    input  logic       key_ack,
    output logic [3:0] row_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down,
    output logic       overflow
);

    localparam int                SLOT_W    = $clog2(SCAN_DIV);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [7:0]        DEB_LAST  = 8'(DEBOUNCE_SAMPLES);

    if (SCAN_DIV < 4 || DEBOUNCE_SAMPLES < 1 || DEBOUNCE_SAMPLES > 255 ||
        REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
        $error("keypad_scanner: illegal parameter value");
    end

    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

    state_t            state, state_nxt;
    logic [1:0]        row, row_nxt;
    logic [7:0]        cnt, cnt_nxt;
    logic [3:0]        cand, cand_nxt;
    logic [3:0]        col_meta, col_sync;
    logic [SLOT_W-1:0] slot_cnt;
    logic              tick;
    logic              any_low;
    logic [1:0]        low_col;
    logic              sample_match;
    logic              report;
    logic [3:0]        report_code;
    logic              repeat_fire;

    // Columns idle high, so the synchronizer resets to 1 to avoid a
    // phantom press straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_meta <= 4'hF;
            col_sync <= 4'hF;
        end else begin
            col_meta <= col_n;
            col_sync <= col_meta;
        end
    end

    // Row slot timer; the last count of each slot is the only moment the
    // columns are looked at, giving the row strobe time to settle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt <= '0;
        end else if (tick) begin
            slot_cnt <= '0;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
        end
    end

    assign tick    = (slot_cnt == SLOT_LAST);
    assign any_low = (col_sync != 4'hF);

    // Later assignments override earlier ones, so the lowest low column wins.
    always_comb begin
        low_col = 2'd0;
        if (!col_sync[3]) low_col = 2'd3;
        if (!col_sync[2]) low_col = 2'd2;
        if (!col_sync[1]) low_col = 2'd1;
        if (!col_sync[0]) low_col = 2'd0;
    end

    // The row is locked outside SCAN, so only the column needs comparing.
    assign sample_match = any_low && (low_col == cand[1:0]);

`ifdef KEYPAD_REPEAT_EN
    localparam logic [15:0] REP_DELAY = 16'(REPEAT_DELAY);
    localparam logic [15:0] REP_RATE  = 16'(REPEAT_RATE);

    logic [15:0] hold_cnt;
    logic        rep_armed;
    logic [15:0] rep_target;

    // The first repeat waits the longer delay; every later one the rate.
    assign rep_target  = rep_armed ? REP_RATE : REP_DELAY;
    assign repeat_fire = tick && (state == PRESSED) && sample_match &&
                         ((hold_cnt + 16'd1) == rep_target);

    // Held-sample counter, restarted whenever PRESSED is left.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt  <= '0;
            rep_armed <= 1'b0;
        end else if (state_nxt != PRESSED) begin
            hold_cnt  <= '0;
            rep_armed <= 1'b0;
        end else if (repeat_fire) begin
            hold_cnt  <= '0;
            rep_armed <= 1'b1;
        end else if (tick && state == PRESSED && sample_match) begin
            hold_cnt  <= hold_cnt + 16'd1;
        end
    end
`else
    assign repeat_fire = 1'b0;
`endif

    // Scanner state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SCAN;
            row   <= 2'd0;
            cnt   <= 8'd0;
            cand  <= 4'd0;
        end else begin
            state <= state_nxt;
            row   <= row_nxt;
            cnt   <= cnt_nxt;
            cand  <= cand_nxt;
        end
    end

    // Next-state logic; everything advances only on a sample tick. With a
    // single required sample the key is accepted on the tick that finds it.
    always_comb begin
        state_nxt   = state;
        row_nxt     = row;
        cnt_nxt     = cnt;
        cand_nxt    = cand;
        report      = 1'b0;
        report_code = cand;
        if (tick) begin
            case (state)
                SCAN: begin
                    if (!any_low) begin
                        row_nxt = row + 2'd1;
                    end else begin
                        cand_nxt = {row, low_col};
                        cnt_nxt  = 8'd1;
                        if (DEB_LAST == 8'd1) begin
                            report      = 1'b1;
                            report_code = {row, low_col};
                            state_nxt   = PRESSED;
                        end else begin
                            state_nxt = DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (sample_match) begin
                        cnt_nxt = cnt + 8'd1;
                        if ((cnt + 8'd1) == DEB_LAST) begin
                            report    = 1'b1;
                            state_nxt = PRESSED;
                        end
                    end else begin
                        state_nxt = SCAN;
                        row_nxt   = row + 2'd1;
                    end
                end
                PRESSED: begin
                    if (!any_low) begin
                        cnt_nxt = 8'd1;
                        if (DEB_LAST == 8'd1) begin
                            state_nxt = SCAN;
                            row_nxt   = row + 2'd1;
                        end else begin
                            state_nxt = RELEASE;
                        end
                    end else if (repeat_fire) begin
                        report = 1'b1;
                    end
                end
                RELEASE: begin
                    if (any_low) begin
                        state_nxt = PRESSED;
                    end else begin
                        cnt_nxt = cnt + 8'd1;
                        if ((cnt + 8'd1) == DEB_LAST) begin
                            state_nxt = SCAN;
                            row_nxt   = row + 2'd1;
                        end
                    end
                end
                default: begin
                    state_nxt = SCAN;
                end
            endcase
        end
    end

    // Consumer handshake: an acknowledge in the same cycle frees the slot
    // for a new report; otherwise a report into a full slot is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            overflow  <= 1'b0;
        end else if (report) begin
            if (!key_valid || key_ack) begin
                key_code  <= report_code;
                key_valid <= 1'b1;
            end else begin
                overflow  <= 1'b1;
            end
        end else if (key_ack && key_valid) begin
            key_valid <= 1'b0;
        end
    end

    assign row_n    = ~(4'b0001 << row);
    assign key_down = (state == PRESSED) || (state == RELEASE);

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SAMPLES=3,
// REPEAT_DELAY=6, REPEAT_RATE=2. A small keypad model pulls one column low
// while the strobed row matches the held key. All steps are aligned so that
// each step_ticks(1) ends 1 time unit after a sample-tick clock edge.

module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] col_n;
    logic       key_ack;
    logic [3:0] row_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;
    logic       overflow;

    logic       pressed;
    logic [3:0] press_key;

    int tests_run    = 0;
    int tests_failed = 0;
    int n_rep;
    int rep_tick [8];

    logic [3:0] exp_rows [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

    keypad_scanner #(
        .SCAN_DIV         (4),
        .DEBOUNCE_SAMPLES (3),
        .REPEAT_DELAY     (6),
        .REPEAT_RATE      (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .col_n     (col_n),
        .key_ack   (key_ack),
        .row_n     (row_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_down  (key_down),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a held key shorts its column to its row strobe.
    always_comb begin
        col_n = 4'hF;
        if (pressed && !row_n[press_key[3:2]]) col_n[press_key[1:0]] = 1'b0;
    end

    task automatic clk_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic step_ticks(input int n);
        clk_n(4 * n);
    endtask

    task automatic check_output(input string tag, input logic [15:0] obs,
                                input logic [15:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Holds reset for two clocks, checks the reset values, then releases
    // reset just after an edge so the next edge starts slot 0.
    task automatic apply_reset(input string tag);
        rst_n = 1'b0;
        clk_n(2);
        check_output({tag, "_row_n"},     16'(row_n),     16'hE);
        check_output({tag, "_key_code"},  16'(key_code),  16'h0);
        check_output({tag, "_key_valid"}, 16'(key_valid), 16'h0);
        check_output({tag, "_key_down"},  16'(key_down),  16'h0);
        check_output({tag, "_overflow"},  16'(overflow),  16'h0);
        rst_n = 1'b1;
    endtask

    // One-clock acknowledge at the start of a tick window (not a tick cycle).
    task automatic ack_window();
        key_ack = 1'b1;
        clk_n(1);
        key_ack = 1'b0;
        clk_n(3);
    endtask

    initial begin
        rst_n     = 1'b0;
        key_ack   = 1'b0;
        pressed   = 1'b0;
        press_key = 4'd0;
        apply_reset("rst0");

        // Idle scanning walks through all four rows, one per slot.
        for (int i = 0; i < 4; i++) begin
            step_ticks(1);
            check_output($sformatf("idle_row%0d", i), 16'(row_n), 16'(exp_rows[i]));
            check_output($sformatf("idle_kv%0d", i), 16'(key_valid), 16'h0);
        end

        // Clean press of key 9 (row 2, col 1) from row 0.
        press_key = 4'd9;
        pressed   = 1'b1;
        step_ticks(4);
        check_output("k9_before_kv", 16'(key_valid), 16'h0);
        step_ticks(1);
        check_output("k9_kv",   16'(key_valid), 16'h1);
        check_output("k9_code", 16'(key_code),  16'h9);
        check_output("k9_down", 16'(key_down),  16'h1);
        ack_window();
        check_output("k9_ack_kv",   16'(key_valid), 16'h0);
        check_output("k9_ack_code", 16'(key_code),  16'h9);
        check_output("k9_ack_down", 16'(key_down),  16'h1);
        pressed = 1'b0;
        step_ticks(2);
        check_output("k9_rel2_down", 16'(key_down), 16'h1);
        step_ticks(1);
        check_output("k9_rel3_down", 16'(key_down), 16'h0);
        check_output("k9_rel3_row",  16'(row_n),    16'h7);

        // Single bounce on key 14 (row 3, col 2), then a clean press.
        press_key = 4'd14;
        pressed   = 1'b1;
        step_ticks(1);
        pressed = 1'b0;
        step_ticks(1);
        check_output("bounce_kv",   16'(key_valid), 16'h0);
        check_output("bounce_down", 16'(key_down),  16'h0);
        check_output("bounce_row",  16'(row_n),     16'hE);
        pressed = 1'b1;
        step_ticks(5);
        check_output("k14_before_kv", 16'(key_valid), 16'h0);
        step_ticks(1);
        check_output("k14_kv",   16'(key_valid), 16'h1);
        check_output("k14_code", 16'(key_code),  16'hE);
        ack_window();
        pressed = 1'b0;
        step_ticks(3);

        // Key 2 bouncing every tick never gets three matching samples.
        press_key = 4'd2;
        for (int i = 0; i < 16; i++) begin
            pressed = (i % 2 == 0);
            step_ticks(1);
        end
        pressed = 1'b0;
        check_output("bforever_kv",   16'(key_valid), 16'h0);
        check_output("bforever_down", 16'(key_down),  16'h0);
        check_output("bforever_ovf",  16'(overflow),  16'h0);

        // Key 5 left unacknowledged, then key 10 is dropped.
        apply_reset("rst1");
        press_key = 4'd5;
        pressed   = 1'b1;
        step_ticks(3);
        check_output("k5_before_kv", 16'(key_valid), 16'h0);
        step_ticks(1);
        check_output("k5_kv",   16'(key_valid), 16'h1);
        check_output("k5_code", 16'(key_code),  16'h5);
        check_output("k5_ovf",  16'(overflow),  16'h0);
        pressed = 1'b0;
        step_ticks(3);
        check_output("k5_rel_down", 16'(key_down), 16'h0);
        check_output("k5_rel_row",  16'(row_n),    16'hB);
        press_key = 4'd10;
        pressed   = 1'b1;
        step_ticks(3);
        check_output("k10_drop_code", 16'(key_code),  16'h5);
        check_output("k10_drop_kv",   16'(key_valid), 16'h1);
        check_output("k10_drop_ovf",  16'(overflow),  16'h1);
        check_output("k10_drop_down", 16'(key_down),  16'h1);
        pressed = 1'b0;
        step_ticks(3);
        check_output("k10_rel_row", 16'(row_n), 16'h7);

        // Key 10 again, with key_ack raised exactly on the report cycle.
        pressed = 1'b1;
        step_ticks(5);
        check_output("k10_pre_code", 16'(key_code), 16'h5);
        clk_n(3);
        key_ack = 1'b1;
        clk_n(1);
        key_ack = 1'b0;
        check_output("k10_ack_code", 16'(key_code),  16'hA);
        check_output("k10_ack_kv",   16'(key_valid), 16'h1);
        check_output("k10_ack_ovf",  16'(overflow),  16'h1);
        pressed = 1'b0;

        // Reset in the middle of debouncing key 3 (row 0, col 3).
        apply_reset("rst2");
        press_key = 4'd3;
        pressed   = 1'b1;
        step_ticks(2);
        check_output("k3_mid_kv", 16'(key_valid), 16'h0);
        apply_reset("rst_mid");
        step_ticks(2);
        check_output("k3_fresh_kv", 16'(key_valid), 16'h0);
        step_ticks(1);
        check_output("k3_kv",   16'(key_valid), 16'h1);
        check_output("k3_code", 16'(key_code),  16'h3);
        pressed = 1'b0;

        // Key 0 held with key_ack high every cycle; record report ticks.
        apply_reset("rst3");
        press_key = 4'd0;
        pressed   = 1'b1;
        key_ack   = 1'b1;
        n_rep     = 0;
        for (int t = 1; t <= 20; t++) begin
            for (int c = 0; c < 4; c++) begin
                clk_n(1);
                if (key_valid === 1'b1) begin
                    if (n_rep < 8) rep_tick[n_rep] = t;
                    n_rep++;
                end
            end
        end
        key_ack = 1'b0;
        pressed = 1'b0;
        check_output("hold_first_tick", 16'(rep_tick[0]), 16'd3);
        check_output("hold_code",       16'(key_code),    16'h0);
`ifdef KEYPAD_REPEAT_EN
        check_output("hold_reports",     16'(n_rep),       16'd7);
        check_output("hold_second_tick", 16'(rep_tick[1]), 16'd9);
        check_output("hold_third_tick",  16'(rep_tick[2]), 16'd11);
`else
        check_output("hold_reports", 16'(n_rep), 16'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
